// File: rtl/simd_pkg.sv
// Shared constants and types for the SIMD core front end.
// Holds the instruction layout, fetch states and the prefetch entry type.
package simd_pkg;

  localparam int ADDR_W = 10;
  localparam int INST_W = 18;
  localparam int OP_HI  = 17;
  localparam int OP_LO  = 12;

  localparam logic [5:0] HALT_OP     = 6'b111111;
  localparam logic [5:0] LOOP_OP     = 6'b100100;
  localparam logic [5:0] LOOP_SET_OP = 6'b100101;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_FETCH     = 2'd1;
  localparam logic [1:0] S_HALT_SEEN = 2'd2;
  localparam logic [1:0] S_HALTED    = 2'd3;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_ent_t;

  function automatic logic [5:0] opcode(
    input logic [INST_W-1:0] i
  );
    return i[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/simd_fetch_fifo.sv
// Prefetch queue: DEPTH entries with flush, occupancy count and
// a combinational head read that reads as zero while empty.
module simd_fetch_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign dout   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && !flush && !do_pop && count == CW'(DEPTH))
  );

endmodule

// File: rtl/simd_inst_fetch.sv
// Instruction fetch front end: credit-limited sequential fetch,
// redirect with in-flight drop, and stop on HALT.
module simd_inst_fetch
  import simd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              halted
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     q_count;
  logic [CW:0]       credit;
  logic              redir;
  logic              issue;
  logic              enq;
  logic              drop;
  logic              pop;
  fetch_ent_t        wr_ent;
  fetch_ent_t        head;

  assign redir  = redirect_valid &&
                  (state == S_FETCH || state == S_HALT_SEEN);
  // Dropped slots still occupy credit until their response returns.
  assign credit = {1'b0, q_count} + {1'b0, outstanding};
  assign issue  = (state == S_FETCH) && !redir && (credit < DEPTH_V);
  assign drop   = imem_rvalid && (drop_cnt != '0);
  assign enq    = imem_rvalid && (drop_cnt == '0) &&
                  (state == S_FETCH) && !redir;
  assign pop    = inst_valid && inst_ready;
  assign wr_ent = '{inst: imem_rdata, pc: resp_pc};

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc;
  assign inst_valid = (q_count != '0);
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;
  assign halted     = (state == S_HALTED);

  simd_fetch_fifo #(
    .W     ($bits(fetch_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redir),
    .push  (enq),
    .din   (wr_ent),
    .pop   (pop),
    .dout  (head),
    .count (q_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      fetch_pc    <= '0;
      resp_pc     <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
      if (redir) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + 1'b1;
        if (enq)
          resp_pc <= resp_pc + 1'b1;
        if (drop)
          drop_cnt <= drop_cnt - 1'b1;
      end
      unique case (state)
        S_IDLE:
          state <= S_FETCH;
        S_FETCH:
          if (enq && opcode(imem_rdata) == HALT_OP)
            state <= S_HALT_SEEN;
        S_HALT_SEEN:
          if (redir)
            state <= S_FETCH;
          else if (pop && opcode(head.inst) == HALT_OP)
            state <= S_HALTED;
        S_HALTED: ;
      endcase
    end
  end

endmodule
